cpu_control_fsm: RTL and testbench

Multi-cycle control unit for the 16-bit CPU. It consumes the decoded instruction fields and processor status flags that the datapath produces. It returns every select and enable signal the datapath needs to step through fetch, decode, execute and writeback. It is the control-side counterpart of the datapath: the datapath moves data, and this block decides when and where that data moves.

---
 rtl/cpu_control_fsm.sv | 149 ++++++++++++++
 tb/tb_cpu_control_fsm.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle control unit (fetch/decode/execute/writeback) for the 16-bit CPU.
// Define CTRL_HALT_ON_ILLEGAL_EN to halt on illegal encodings instead of executing them as NOPs.
module cpu_control_fsm #(
    parameter int MEM_LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] OpCode,
    input  logic [3:0] Rdest,
    input  logic [3:0] ImmHi_OpExt,
    input  logic [4:0] psr,
    output logic       instr_en,
    output logic       pc_en,
    output logic [1:0] pc_sel,
    output logic       mem_addr_sel,
    output logic       mem_wr_en,
    output logic       reg_wr_en,
    output logic [1:0] reg_wr_sel,
    output logic       alu_b_sel,
    output logic       imm_zext,
    output logic [3:0] alu_op,
    output logic       psr_en,
    output logic       halted
);
    typedef enum logic [2:0] {FETCH, WAIT, DECODE, EXEC, LOAD_WB, HALT} state_t;
`ifdef CTRL_HALT_ON_ILLEGAL_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif
    state_t state, next_state;
    logic wb_wait;
    logic is_load, illegal, cond_true;
    logic [7:0] cond_base;

    function automatic logic flag_op(input logic [3:0] c);
        return c inside {4'b0101, 4'b0110, 4'b0111, 4'b1001, 4'b1011};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            wb_wait <= 1'b0;
        end else begin
            state   <= next_state;
            wb_wait <= (MEM_LATENCY == 2) && state == EXEC && is_load;
        end
    end

    // psr = {C, L, F, Z, N}; odd condition codes are the complement of the even one below them
    always_comb begin
        cond_base = {1'b1, ~psr[0] & ~psr[1], ~psr[3] & ~psr[1], psr[2], psr[0], psr[3], psr[4], psr[1]};
        cond_true = cond_base[Rdest[3:1]] ^ Rdest[0];
        is_load   = OpCode == 4'b0100 && ImmHi_OpExt == 4'b0000;
        illegal   = OpCode inside {4'b1010, 4'b1110}
                 || (OpCode == 4'b0000 && !(ImmHi_OpExt inside {4'b0001, 4'b0010, 4'b0011, 4'b0101,
                                                                 4'b0110, 4'b0111, 4'b1001, 4'b1011, 4'b1101}))
                 || (OpCode == 4'b0100 && ImmHi_OpExt[1:0] != 2'b00)
                 || (OpCode == 4'b1000 && ImmHi_OpExt[3:1] != 3'b000 && ImmHi_OpExt != 4'b0100);
    end

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:   next_state = MEM_LATENCY == 2 ? WAIT : DECODE;
            WAIT:    next_state = DECODE;
            DECODE:  next_state = EXEC;
            EXEC:    next_state = is_load ? LOAD_WB : (illegal && HALT_EN) ? HALT : FETCH;
            LOAD_WB: next_state = wb_wait ? LOAD_WB : FETCH;
            HALT:    next_state = HALT;
            default: next_state = FETCH;
        endcase
    end

    // Enables are gated by reset so an interrupted instruction never commits a write
    always_comb begin
        instr_en     = 1'b0;
        pc_en        = 1'b0;
        pc_sel       = 2'b00;
        mem_addr_sel = 1'b0;
        mem_wr_en    = 1'b0;
        reg_wr_en    = 1'b0;
        reg_wr_sel   = 2'b00;
        alu_b_sel    = 1'b0;
        imm_zext     = 1'b0;
        alu_op       = 4'b0000;
        psr_en       = 1'b0;
        if (!reset) begin
            case (state)
                DECODE: instr_en = 1'b1;
                EXEC: begin
                    if (illegal) begin
                        pc_en = !HALT_EN;
                    end else begin
                        case (OpCode)
                            4'b0000: begin
                                alu_op    = ImmHi_OpExt;
                                reg_wr_en = ImmHi_OpExt != 4'b1011;
                                psr_en    = flag_op(ImmHi_OpExt);
                                pc_en     = 1'b1;
                            end
                            4'b1000: begin
                                alu_op    = 4'b1000;
                                alu_b_sel = ImmHi_OpExt[3:1] == 3'b000;
                                reg_wr_en = 1'b1;
                                pc_en     = 1'b1;
                            end
                            4'b0100: begin
                                mem_addr_sel = !ImmHi_OpExt[3];
                                mem_wr_en    = ImmHi_OpExt == 4'b0100;
                                pc_en        = !is_load;
                                reg_wr_en    = ImmHi_OpExt == 4'b1000;
                                reg_wr_sel   = {ImmHi_OpExt == 4'b1000, 1'b0};
                                pc_sel       = {ImmHi_OpExt == 4'b1000 || (ImmHi_OpExt == 4'b1100 && cond_true), 1'b0};
                            end
                            4'b1100: begin
                                pc_en  = 1'b1;
                                pc_sel = {1'b0, cond_true};
                            end
                            default: begin
                                alu_op    = OpCode;
                                alu_b_sel = 1'b1;
                                imm_zext  = OpCode inside {4'b0001, 4'b0010, 4'b0011, 4'b1111};
                                reg_wr_en = OpCode != 4'b1011;
                                psr_en    = flag_op(OpCode);
                                pc_en     = 1'b1;
                            end
                        endcase
                    end
                end
                LOAD_WB: begin
                    mem_addr_sel = 1'b1;
                    if (!wb_wait) begin
                        reg_wr_sel = 2'b01;
                        reg_wr_en  = 1'b1;
                        pc_en      = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CTRL_HALT_ON_ILLEGAL_EN
    assign halted = state == HALT;
`else
    assign halted = 1'b0;
`endif
endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb_cpu_control_fsm: directed self-checking bench for cpu_control_fsm (MEM_LATENCY = 1).
module tb_cpu_control_fsm;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] OpCode = '0, Rdest = '0, ImmHi_OpExt = '0;
    logic [4:0] psr = '0;
    logic       instr_en, pc_en, mem_addr_sel, mem_wr_en, reg_wr_en, alu_b_sel, imm_zext, psr_en, halted;
    logic [1:0] pc_sel, reg_wr_sel;
    logic [3:0] alu_op;
    logic [16:0] outs;
    int errors = 0;
    int checks = 0;

    cpu_control_fsm dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Rdest(Rdest), .ImmHi_OpExt(ImmHi_OpExt), .psr(psr),
        .instr_en(instr_en), .pc_en(pc_en), .pc_sel(pc_sel), .mem_addr_sel(mem_addr_sel),
        .mem_wr_en(mem_wr_en), .reg_wr_en(reg_wr_en), .reg_wr_sel(reg_wr_sel), .alu_b_sel(alu_b_sel),
        .imm_zext(imm_zext), .alu_op(alu_op), .psr_en(psr_en), .halted(halted)
    );

    always #5 clk = ~clk;

    assign outs = {instr_en, pc_en, pc_sel, mem_addr_sel, mem_wr_en, reg_wr_en, reg_wr_sel,
                   alu_b_sel, imm_zext, alu_op, psr_en, halted};

    function automatic logic [16:0] ov(input logic ie, pe, input logic [1:0] ps, input logic ma, mw, rw,
                                       input logic [1:0] rs, input logic bs, iz, input logic [3:0] op,
                                       input logic pse, h);
        return {ie, pe, ps, ma, mw, rw, rs, bs, iz, op, pse, h};
    endfunction

    localparam logic [16:0] ZERO = '0;
    logic [16:0] dec_v;

    task automatic set_instr(input logic [3:0] op, rd, ext, input logic [4:0] p);
        OpCode = op; Rdest = rd; ImmHi_OpExt = ext; psr = p;
    endtask

    task automatic test_reset();
        set_instr(4'b0000, 4'b0001, 4'b0101, 5'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (outs !== ZERO) begin errors++; $display("FAIL reset_outputs: got %h expected %h", outs, ZERO); end
        reset = 1'b0;
        #1;
        checks++; if (outs !== ZERO) begin errors++; $display("FAIL fetch_after_reset: got %h expected %h", outs, ZERO); end
        @(negedge clk);
        checks++; if (outs !== dec_v) begin errors++; $display("FAIL decode_cycle2: got %h expected %h", outs, dec_v); end
        @(negedge clk);
        checks++; if (outs !== ov(0,1,2'b00,0,0,1,2'b00,0,0,4'b0101,1,0)) begin errors++;
            $display("FAIL add_exec: got %h expected %h", outs, ov(0,1,2'b00,0,0,1,2'b00,0,0,4'b0101,1,0)); end
        @(negedge clk);
        checks++; if (outs !== ZERO) begin errors++; $display("FAIL add_next_fetch: got %h expected %h", outs, ZERO); end
    endtask

    task automatic test_alu();
        logic [3:0] op [0:3];
        logic [3:0] ext [0:3];
        logic [16:0] exp_v [0:3];
        op  = '{4'b1011, 4'b0010, 4'b1000, 4'b1000};
        ext = '{4'b0000, 4'b0000, 4'b0100, 4'b0001};
        exp_v[0] = ov(0,1,2'b00,0,0,0,2'b00,1,0,4'b1011,1,0);
        exp_v[1] = ov(0,1,2'b00,0,0,1,2'b00,1,1,4'b0010,0,0);
        exp_v[2] = ov(0,1,2'b00,0,0,1,2'b00,0,0,4'b1000,0,0);
        exp_v[3] = ov(0,1,2'b00,0,0,1,2'b00,1,0,4'b1000,0,0);
        for (int i = 0; i < 4; i++) begin
            set_instr(op[i], 4'b0011, ext[i], 5'b0);
            @(negedge clk);
            checks++; if (outs !== dec_v) begin errors++; $display("FAIL alu_decode[%0d]: got %h expected %h", i, outs, dec_v); end
            @(negedge clk);
            checks++; if (outs !== exp_v[i]) begin errors++; $display("FAIL alu_exec[%0d]: got %h expected %h", i, outs, exp_v[i]); end
            @(negedge clk);
            checks++; if (outs !== ZERO) begin errors++; $display("FAIL alu_fetch[%0d]: got %h expected %h", i, outs, ZERO); end
        end
    endtask

    task automatic test_load_store();
        set_instr(4'b0100, 4'b0010, 4'b0000, 5'b0);
        @(negedge clk);
        checks++; if (outs !== dec_v) begin errors++; $display("FAIL load_decode: got %h expected %h", outs, dec_v); end
        @(negedge clk);
        checks++; if (outs !== ov(0,0,2'b00,1,0,0,2'b00,0,0,4'b0,0,0)) begin errors++;
            $display("FAIL load_exec: got %h expected %h", outs, ov(0,0,2'b00,1,0,0,2'b00,0,0,4'b0,0,0)); end
        @(negedge clk);
        checks++; if (outs !== ov(0,1,2'b00,1,0,1,2'b01,0,0,4'b0,0,0)) begin errors++;
            $display("FAIL load_wb: got %h expected %h", outs, ov(0,1,2'b00,1,0,1,2'b01,0,0,4'b0,0,0)); end
        @(negedge clk);
        checks++; if (outs !== ZERO) begin errors++; $display("FAIL load_fetch: got %h expected %h", outs, ZERO); end
        set_instr(4'b0100, 4'b0010, 4'b0100, 5'b0);
        @(negedge clk);
        checks++; if (outs !== dec_v) begin errors++; $display("FAIL stor_decode: got %h expected %h", outs, dec_v); end
        @(negedge clk);
        checks++; if (outs !== ov(0,1,2'b00,1,1,0,2'b00,0,0,4'b0,0,0)) begin errors++;
            $display("FAIL stor_exec: got %h expected %h", outs, ov(0,1,2'b00,1,1,0,2'b00,0,0,4'b0,0,0)); end
        @(negedge clk);
        checks++; if (outs !== ZERO) begin errors++; $display("FAIL stor_fetch: got %h expected %h", outs, ZERO); end
    endtask

    task automatic test_branch();
        logic [3:0] op [0:7];
        logic [3:0] rd [0:7];
        logic [3:0] ext [0:7];
        logic [4:0] p [0:7];
        logic [16:0] exp_v [0:7];
        op  = '{4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b0100, 4'b0100, 4'b0100};
        rd  = '{4'b0000, 4'b0000, 4'b1111, 4'b1010, 4'b0110, 4'b0011, 4'b1110, 4'b0000};
        ext = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1100, 4'b1100};
        p   = '{5'b00010, 5'b00000, 5'b11111, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b00000};
        exp_v[0] = ov(0,1,2'b01,0,0,0,2'b00,0,0,4'b0,0,0);
        exp_v[1] = ov(0,1,2'b00,0,0,0,2'b00,0,0,4'b0,0,0);
        exp_v[2] = ov(0,1,2'b00,0,0,0,2'b00,0,0,4'b0,0,0);
        exp_v[3] = ov(0,1,2'b01,0,0,0,2'b00,0,0,4'b0,0,0);
        exp_v[4] = ov(0,1,2'b01,0,0,0,2'b00,0,0,4'b0,0,0);
        exp_v[5] = ov(0,1,2'b10,0,0,1,2'b10,0,0,4'b0,0,0);
        exp_v[6] = ov(0,1,2'b10,0,0,0,2'b00,0,0,4'b0,0,0);
        exp_v[7] = ov(0,1,2'b00,0,0,0,2'b00,0,0,4'b0,0,0);
        for (int i = 0; i < 8; i++) begin
            set_instr(op[i], rd[i], ext[i], p[i]);
            @(negedge clk);
            checks++; if (outs !== dec_v) begin errors++; $display("FAIL branch_decode[%0d]: got %h expected %h", i, outs, dec_v); end
            @(negedge clk);
            checks++; if (outs !== exp_v[i]) begin errors++; $display("FAIL branch_exec[%0d]: got %h expected %h", i, outs, exp_v[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        set_instr(4'b1010, 4'b0001, 4'b0000, 5'b0);
        @(negedge clk);
        checks++; if (outs !== dec_v) begin errors++; $display("FAIL illegal_decode: got %h expected %h", outs, dec_v); end
        @(negedge clk);
`ifdef CTRL_HALT_ON_ILLEGAL_EN
        checks++; if (outs !== ZERO) begin errors++; $display("FAIL illegal_exec: got %h expected %h", outs, ZERO); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (outs !== ov(0,0,2'b00,0,0,0,2'b00,0,0,4'b0,0,1)) begin errors++;
                $display("FAIL halt_hold[%0d]: got %h expected %h", i, outs, ov(0,0,2'b00,0,0,0,2'b00,0,0,4'b0,0,1)); end
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (outs !== ZERO) begin errors++; $display("FAIL halt_cleared: got %h expected %h", outs, ZERO); end
`else
        checks++; if (outs !== ov(0,1,2'b00,0,0,0,2'b00,0,0,4'b0,0,0)) begin errors++;
            $display("FAIL illegal_nop: got %h expected %h", outs, ov(0,1,2'b00,0,0,0,2'b00,0,0,4'b0,0,0)); end
        @(negedge clk);
        checks++; if (outs !== ZERO) begin errors++; $display("FAIL illegal_fetch: got %h expected %h", outs, ZERO); end
`endif
    endtask

    task automatic test_reset_mid();
        set_instr(4'b0100, 4'b0101, 4'b0000, 5'b0);
        @(negedge clk);
        checks++; if (outs !== dec_v) begin errors++; $display("FAIL mid_decode: got %h expected %h", outs, dec_v); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (reg_wr_en !== 1'b0 || pc_en !== 1'b0) begin errors++;
            $display("FAIL mid_reset_wb: got reg_wr_en=%b pc_en=%b expected 0 0", reg_wr_en, pc_en); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (outs !== ZERO) begin errors++; $display("FAIL mid_restart_fetch: got %h expected %h", outs, ZERO); end
        @(negedge clk);
        checks++; if (outs !== dec_v) begin errors++; $display("FAIL mid_restart_decode: got %h expected %h", outs, dec_v); end
    endtask

    initial begin
        dec_v = ov(1,0,2'b00,0,0,0,2'b00,0,0,4'b0,0,0);
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_illegal();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
